dm_job_scheduler: RTL and testbench

Queues data-mover jobs and launches them on the data mover one at a time. It sits between job producers (host register logic or an on-chip sequencer) and the data mover's src_address/dst_address/byte_count/start/idle control port. It also retires each job with a done or error indication and keeps a running completion count.

---
 rtl/dm_job_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_dm_job_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_job_scheduler.sv
// dm_job_scheduler
//
// Queues data-mover jobs {src, dst, count} in a FIFO. It launches them one at a time on the
// mover's src_address/dst_address/byte_count/start/idle control port. Each job retires with
// a job_done pulse, qualified by job_err. A running completion count is kept.
//
// Configuration macro: DM_SCHED_SKIP_ZERO_EN
//   defined   - a popped job with count == 0 (and dst != 0) retires immediately with
//               job_done=1, job_err=0. It is not launched, and the output registers are
//               left unchanged.
//   undefined - zero-count jobs are launched like any other job.
//
// Parameters:
//   DEPTH         job FIFO depth (power of two, 2..64)
//   BUSY_TIMEOUT  cycles to wait for idle to drop after start (1..255)
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   enable                      allow launching (pushes are accepted regardless)
//   push_src/dst/count, push_valid, push_ready
//                               job producer interface
//   src_address, dst_address, byte_count, start, idle
//                               data mover control port
//   job_done, job_err           retire pulse and its error qualifier
//   busy                        FSM is not idle
//   queue_level                 jobs held in the FIFO
//   completed                   count of job_done pulses (wraps)

module dm_job_scheduler #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [63:0]              push_src,
    input  logic [63:0]              push_dst,
    input  logic [63:0]              push_count,
    input  logic                     push_valid,
    output logic                     push_ready,
    output logic [63:0]              src_address,
    output logic [63:0]              dst_address,
    output logic [63:0]              byte_count,
    output logic                     start,
    input  logic                     idle,
    output logic                     job_done,
    output logic                     job_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic [31:0]              completed
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE      = (AW + 1)'(1);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t state_q, state_d;

    logic [191:0] mem [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic [7:0]   timer_q, timer_d;

    logic [63:0]  src_q, dst_q, cnt_q;
    logic         start_q, done_q, err_q;
    logic [31:0]  completed_q;

    logic         push, pop, launch, done_d, err_d, empty;
    logic [191:0] head;
    logic [63:0]  head_src, head_dst, head_count;

    // Pointers carry one extra bit, so the full and empty states stay distinct.
    assign queue_level = wptr_q - rptr_q;
    assign empty       = (queue_level == '0);
    assign push_ready  = (queue_level != FULL_LEVEL);
    assign push        = push_valid && push_ready;

    assign head       = mem[rptr_q[AW-1:0]];
    assign head_src   = head[191:128];
    assign head_dst   = head[127:64];
    assign head_count = head[63:0];

    // Storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= {push_src, push_dst, push_count};
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        launch  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && enable && idle) begin
                    pop = 1'b1;
                    if (head_dst == '0) begin
                        // The mover refuses a null destination, so retire the job as an error.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
`ifdef DM_SCHED_SKIP_ZERO_EN
                    else if (head_count == '0) begin
                        done_d = 1'b1;
                    end
`endif
                    else begin
                        launch  = 1'b1;
                        state_d = S_WAIT_BUSY;
                        timer_d = '0;
                    end
                end
            end
            S_WAIT_BUSY: begin
                if (!idle) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (idle) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            completed_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            start_q <= launch;
            done_q  <= done_d;
            err_q   <= err_d;
            if (push) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            if (launch) begin
                src_q <= head_src;
                dst_q <= head_dst;
                cnt_q <= head_count;
            end
            if (done_d) begin
                completed_q <= completed_q + 32'd1;
            end
        end
    end

    assign src_address = src_q;
    assign dst_address = dst_q;
    assign byte_count  = cnt_q;
    assign start       = start_q;
    assign job_done    = done_q;
    assign job_err     = err_q;
    assign busy        = (state_q != S_IDLE);
    assign completed   = completed_q;

endmodule

// File: tb/tb_dm_job_scheduler.sv
// Self-checking bench for dm_job_scheduler: directed vector table plus hand-written
// sequences for reset, fill/back-to-back, timeout and reset during a running job.

module tb_dm_job_scheduler;

    localparam int DEPTH = 8;
    localparam int BT    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] push_src = '0;
    logic [63:0] push_dst = '0;
    logic [63:0] push_count = '0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [63:0] src_address, dst_address, byte_count;
    logic        start;
    logic        idle = 1'b1;
    logic        job_done, job_err, busy;
    logic [3:0]  queue_level;
    logic [31:0] completed;

    always #5 clk = ~clk;

    dm_job_scheduler #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .push_src    (push_src),
        .push_dst    (push_dst),
        .push_count  (push_count),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .src_address (src_address),
        .dst_address (dst_address),
        .byte_count  (byte_count),
        .start       (start),
        .idle        (idle),
        .job_done    (job_done),
        .job_err     (job_err),
        .busy        (busy),
        .queue_level (queue_level),
        .completed   (completed)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Mover model: idle drops the cycle after start and stays low for mv_len cycles.
    // In mode 1 it ignores start entirely.
    int mv_mode = 0;
    int mv_len  = 2;
    int mv_cnt  = 0;
    bit mv_busy = 1'b0;
    always @(posedge clk) begin
        if (mv_busy) begin
            if (mv_cnt <= 1) begin
                idle    <= 1'b1;
                mv_busy <= 1'b0;
            end else begin
                mv_cnt <= mv_cnt - 1;
            end
        end else if (start && mv_mode == 0) begin
            idle    <= 1'b0;
            mv_busy <= 1'b1;
            mv_cnt  <= mv_len;
        end
    end

    // Monitor on the falling edge, away from output updates.
    int          start_cnt = 0;
    int          done_cnt  = 0;
    int          start_cyc = 0;
    int          bad_err   = 0;
    logic [63:0] launched_dst[$];
    int          start_cycs[$];
    always @(negedge clk) begin
        if (start) begin
            start_cnt++;
            start_cyc = cyc;
            launched_dst.push_back(dst_address);
            start_cycs.push_back(cyc);
        end
        if (job_done) done_cnt++;
        if (job_err && !job_done) bad_err++;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int push_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] s, input logic [63:0] d, input logic [63:0] c);
        push_src   = s;
        push_dst   = d;
        push_count = c;
        push_valid = 1'b1;
        push_cyc   = cyc;
        step();
        push_valid = 1'b0;
    endtask

    // Leaves the caller in the cycle where job_done is high (if seen).
    task automatic wait_done(input int budget, output bit ok, output int dcyc);
        ok   = 1'b0;
        dcyc = 0;
        for (int i = 0; i < budget; i++) begin
            if (job_done) begin
                ok   = 1'b1;
                dcyc = cyc;
                break;
            end
            step();
        end
    endtask

    typedef struct {
        logic [63:0] src;
        logic [63:0] dst;
        logic [63:0] cnt;
        bit          launch;
        bit          err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit          ok;
        int          dcyc;
        int          s0, d0;
        logic [63:0] exp_src, exp_dst, exp_cnt;

        vecs[0] = '{src: 64'h2000, dst: 64'h0, cnt: 64'h10, launch: 1'b0, err: 1'b1};
        vecs[1] = '{src: 64'h3000, dst: 64'h4000, cnt: 64'h20, launch: 1'b1, err: 1'b0};
        vecs[2] = '{src: 64'hFFFF_FFFF_FFFF_FFFF, dst: 64'h8000_0000_0000_0000,
                    cnt: 64'hABCD, launch: 1'b1, err: 1'b0};
`ifdef DM_SCHED_SKIP_ZERO_EN
        vecs[3] = '{src: 64'h5000, dst: 64'h6000, cnt: 64'h0, launch: 1'b0, err: 1'b0};
`else
        vecs[3] = '{src: 64'h5000, dst: 64'h6000, cnt: 64'h0, launch: 1'b1, err: 1'b0};
`endif
        vecs[4] = '{src: 64'h0, dst: 64'h1, cnt: 64'h1, launch: 1'b1, err: 1'b0};

        // Reset values
        repeat (3) step();
        check("rst push_ready", push_ready, 1);
        check("rst start", start, 0);
        check("rst job_done", job_done, 0);
        check("rst job_err", job_err, 0);
        check("rst busy", busy, 0);
        check("rst src", src_address, 0);
        check("rst dst", dst_address, 0);
        check("rst count", byte_count, 0);
        check("rst level", queue_level, 0);
        check("rst completed", completed, 0);
        reset = 1'b0;
        step();

        // Single job
        enable = 1'b1;
        mv_len = 100;
        s0     = start_cnt;
        push(64'h1000, 64'h1_0000_0000, 64'h4000);
        check("single level after push", queue_level, 1);
        check("single no start yet", start, 0);
        step();
        check("single start", start, 1);
        check("single busy", busy, 1);
        check("single src", src_address, 64'h1000);
        check("single dst", dst_address, 64'h1_0000_0000);
        check("single count", byte_count, 64'h4000);
        check("single level popped", queue_level, 0);
        step();
        check("single start one cycle", start, 0);
        wait_done(300, ok, dcyc);
        check("single done seen", ok, 1);
        check("single err", job_err, 0);
        check("single done latency", 64'(dcyc - start_cyc), 64'(mv_len + 2));
        check("single completed", completed, 1);
        step();
        check("single start count", 64'(start_cnt - s0), 1);
        exp_src = 64'h1000;
        exp_dst = 64'h1_0000_0000;
        exp_cnt = 64'h4000;

        // Vector table
        mv_len = 2;
        for (int i = 0; i < 5; i++) begin
            s0 = start_cnt;
            push(vecs[i].src, vecs[i].dst, vecs[i].cnt);
            wait_done(100, ok, dcyc);
            check($sformatf("vec%0d done seen", i), ok, 1);
            check($sformatf("vec%0d err", i), job_err, vecs[i].err);
            check($sformatf("vec%0d latency", i), 64'(dcyc - push_cyc),
                  64'(vecs[i].launch ? mv_len + 4 : 2));
            if (vecs[i].launch) begin
                exp_src = vecs[i].src;
                exp_dst = vecs[i].dst;
                exp_cnt = vecs[i].cnt;
            end
            check($sformatf("vec%0d src", i), src_address, exp_src);
            check($sformatf("vec%0d dst", i), dst_address, exp_dst);
            check($sformatf("vec%0d count", i), byte_count, exp_cnt);
            step();
            step();
            check($sformatf("vec%0d starts", i), 64'(start_cnt - s0), 64'(vecs[i].launch));
        end
        check("vec completed", completed, 6);

        // Fill while disabled, then drain back-to-back
        enable = 1'b0;
        mv_len = 3;
        step();
        launched_dst.delete();
        start_cycs.delete();
        s0 = start_cnt;
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            push_src   = 64'h9000 + 64'(i);
            push_dst   = 64'h10000 + 64'(i) * 64'h100;
            push_count = 64'(i + 1);
            push_valid = 1'b1;
            step();
        end
        check("full level", queue_level, 8);
        check("full push_ready", push_ready, 0);
        push_dst = 64'hDEAD;
        step();
        push_valid = 1'b0;
        check("ninth rejected level", queue_level, 8);
        enable = 1'b1;
        ok     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt - d0 >= 8) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("drain finished", ok, 1);
        repeat (10) step();
        check("drain starts", 64'(start_cnt - s0), 8);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain order %0d", i),
                  (i < launched_dst.size()) ? launched_dst[i] : 64'hX,
                  64'h10000 + 64'(i) * 64'h100);
        end
        check("min spacing", (start_cycs.size() > 1) ? 64'(start_cycs[1] - start_cycs[0]) : 0,
              64'(mv_len + 3));
        check("drain completed", completed, 14);
        check("drain level", queue_level, 0);

        // Timeout: mover never leaves idle
        mv_mode = 1;
        push(64'h7000, 64'h8000, 64'h40);
        wait_done(80, ok, dcyc);
        check("timeout done seen", ok, 1);
        check("timeout err", job_err, 1);
        check("timeout latency", 64'(dcyc - start_cyc), BT);
        step();
        check("timeout busy cleared", busy, 0);
        mv_mode = 0;

        // Reset while waiting for the mover, with 3 jobs queued
        mv_len = 100;
        push(64'hA000, 64'hB000, 64'h10);
        push(64'hA100, 64'hB100, 64'h10);
        push(64'hA200, 64'hB200, 64'h10);
        push(64'hA300, 64'hB300, 64'h10);
        repeat (3) step();
        check("pre-reset level", queue_level, 3);
        check("pre-reset busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid rst level", queue_level, 0);
        check("mid rst start", start, 0);
        check("mid rst busy", busy, 0);
        check("mid rst completed", completed, 0);
        check("mid rst push_ready", push_ready, 1);
        step();
        reset = 1'b0;
        s0 = start_cnt;
        d0 = done_cnt;
        repeat (130) step();
        check("post rst no done", 64'(done_cnt - d0), 0);
        check("post rst no start", 64'(start_cnt - s0), 0);
        check("err only with done", 64'(bad_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
